// File: rtl/bit_deframer_pkg.sv
// Shared types and default constants for the bit deframer.
package bit_deframer_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT        = 8'hA5;
    localparam int         FRAME_WORDS_DEFAULT = 4;

endpackage

// File: rtl/deframer_shifter.sv
// MSB-first shift register with payload bit counter; flags sync matches and word completion.
module deframer_shifter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             count_en,
    input  logic             flush,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic             sync_hit
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, sr_next;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;

    assign sr_next   = {sr_q[WIDTH-2:0], bit_in};
    assign word      = sr_next;
    assign word_done = shift_en && count_en && (bit_cnt_q == LAST_BIT);
    assign sync_hit  = shift_en && !count_en && (sr_next == SYNC_WORD);

    // Flush wins over a shift so a frame end or error leaves nothing behind.
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (flush) begin
            sr_d      = '0;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            sr_d = sr_next;
            if (count_en) begin
                bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/bit_deframer.sv
// Sync-hunting deframer with complement check, single-entry valid/ready output and sticky error flags.
//   state   | meaning
//   HUNT    | shifting bits looking for SYNC_WORD
//   PAYLOAD | assembling FRAME_WORDS payload words
module bit_deframer
    import bit_deframer_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_DEFAULT),
    parameter int               FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q_in,
    input  logic             qb_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             err_comp,
    output logic             overflow,
    input  logic             clear
);

    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    state_t           state_q, state_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             locked_q, locked_d;
    logic             err_comp_q, err_comp_d;
    logic             overflow_q, overflow_d;

    logic             bit_good, bit_bad, shift_en, flush;
    logic             word_done, sync_hit, load, drop;
    logic [WIDTH-1:0] word;

    // X or Z on either rail must not pass as a good bit.
    always_comb begin
        bit_good = 1'b0;
        if (q_in ^ qb_in) bit_good = 1'b1;
    end

    assign bit_bad  = bit_en && !bit_good;
    assign shift_en = bit_en && bit_good;

    deframer_shifter #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (shift_en),
        .bit_in    (q_in),
        .count_en  (state_q == PAYLOAD),
        .flush     (flush),
        .word      (word),
        .word_done (word_done),
        .sync_hit  (sync_hit)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        flush      = 1'b0;
        if (bit_bad) begin
            state_d    = HUNT;
            word_cnt_d = '0;
            flush      = 1'b1;
        end else begin
            case (state_q)
                HUNT: begin
                    if (sync_hit) begin
                        state_d    = PAYLOAD;
                        word_cnt_d = '0;
                    end
                end
                PAYLOAD: begin
                    if (word_done) begin
                        if (word_cnt_q == LAST_WORD) begin
                            state_d    = HUNT;
                            word_cnt_d = '0;
                            flush      = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A dropped word still advances the word counter above.
    assign load = word_done && (!out_valid_q || out_ready);
    assign drop = word_done && out_valid_q && !out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        locked_d   = (state_d == PAYLOAD);
        err_comp_d = (err_comp_q && !clear) || bit_bad;
        overflow_d = (overflow_q && !clear) || drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_comp_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            err_comp_q  <= err_comp_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign err_comp  = err_comp_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bit_deframer.sv
// Randomized and directed bench for bit_deframer against a frame-level reference model.
module tb_bit_deframer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       q_in = 1'b0, qb_in = 1'b1, bit_en = 1'b0, out_ready = 1'b0, clear = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, locked, err_comp, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit       m_locked, m_valid, m_err, m_ovf;
    int       m_window, m_cur, m_nbits, m_words;
    bit [7:0] m_data;

    always #5 clk = ~clk;

    bit_deframer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q_in      (q_in),
        .qb_in     (qb_in),
        .bit_en    (bit_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .err_comp  (err_comp),
        .overflow  (overflow),
        .clear     (clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_valid = 0; m_err = 0; m_ovf = 0;
        m_window = 0; m_cur = 0; m_nbits = 0; m_words = 0; m_data = '0;
    endtask

    task automatic model_step();
        bit       done, err_set, ovf_set;
        bit [7:0] w;
        done = 0; err_set = 0; ovf_set = 0; w = '0;
        if (bit_en) begin
            if (q_in == qb_in) begin
                err_set = 1; m_locked = 0; m_window = 0; m_nbits = 0; m_words = 0;
            end else if (!m_locked) begin
                m_window = ((m_window << 1) | int'(q_in)) & 8'hFF;
                if (m_window == 8'hA5) begin
                    m_locked = 1; m_nbits = 0; m_words = 0; m_cur = 0;
                end
            end else begin
                m_cur = ((m_cur << 1) | int'(q_in)) & 8'hFF;
                m_nbits++;
                if (m_nbits == 8) begin
                    done = 1; w = 8'(m_cur); m_nbits = 0; m_words++;
                    if (m_words == 4) begin
                        m_locked = 0; m_window = 0;
                    end
                end
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_data = w; m_valid = 1;
            end else begin
                ovf_set = 1;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
        m_err = (m_err && !clear) || err_set;
        m_ovf = (m_ovf && !clear) || ovf_set;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},     32'(out_data),  32'(m_data));
        check({tag, ".valid"},    32'(out_valid), 32'(m_valid));
        check({tag, ".locked"},   32'(locked),    32'(m_locked));
        check({tag, ".err_comp"}, 32'(err_comp),  32'(m_err));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    task automatic cyc(input logic en, input logic qv, input logic qbv,
                       input logic rdy, input logic clr);
        bit_en = en; q_in = qv; qb_in = qbv; out_ready = rdy; clear = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all("model");
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy);
        for (int i = 7; i >= 0; i--) cyc(1'b1, b[i], ~b[i], rdy, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bit_en = 1'b0; out_ready = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bit         q_bits[$];
        bit         en, bad, qv;

        model_reset();
        #2;
        do_reset();

        // Sync detect then a single payload word
        send_byte(8'hA5, 1'b1);
        check("sync_locked", 32'(locked), 32'd1);
        send_byte(8'h3C, 1'b1);
        check("sync_word_data", 32'(out_data), 32'h3C);
        check("sync_word_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("sync_valid_one_cycle", 32'(out_valid), 32'd0);

        // Full frame, then a trailing byte is ignored
        do_reset();
        send_byte(8'hA5, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i * 8'h11);
            send_byte(b, 1'b1);
            check("frame_data", 32'(out_data), 32'(b));
            check("frame_valid", 32'(out_valid), 32'd1);
        end
        check("frame_unlocked", 32'(locked), 32'd0);
        send_byte(8'h55, 1'b1);
        check("frame_trailing_valid", 32'(out_valid), 32'd0);
        check("frame_trailing_locked", 32'(locked), 32'd0);

        // Backpressure: second word dropped, first held, clear drops overflow
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("bp_held_data", 32'(out_data), 32'h11);
        check("bp_overflow", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bp_clear", 32'(overflow), 32'd0);
        check("bp_still_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("bp_accepted", 32'(out_valid), 32'd0);

        // Complement error mid-word, with clear in the same cycle
        do_reset();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1), 1'(~i & 1), 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("comp_err", 32'(err_comp), 32'd1);
        check("comp_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1), 1'(~i & 1), 1'b1, 1'b0);
        check("comp_no_partial", 32'(out_valid), 32'd0);
        send_byte(8'hA5, 1'b1);
        check("comp_relock", 32'(locked), 32'd1);
        send_byte(8'h77, 1'b1);
        check("comp_relock_data", 32'(out_data), 32'h77);

        // Word completes while the held word is being accepted
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b0);
        b = 8'hC3;
        for (int i = 7; i >= 1; i--) cyc(1'b1, b[i], ~b[i], 1'b0, 1'b0);
        cyc(1'b1, b[0], ~b[0], 1'b1, 1'b0);
        check("simul_data", 32'(out_data), 32'hC3);
        check("simul_valid", 32'(out_valid), 32'd1);
        check("simul_no_ovf", 32'(overflow), 32'd0);

        // Randomized stream with injected sync words, gaps, stalls and bad bits
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (q_bits.size() == 0) begin
                b = ($urandom_range(0, 99) < 35) ? 8'hA5 : 8'($urandom);
                for (int i = 7; i >= 0; i--) q_bits.push_back(b[i]);
            end
            en  = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 199) == 0);
            if (en) begin
                qv = q_bits.pop_front();
                if (bad) cyc(1'b1, qv, qv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
                else     cyc(1'b1, qv, ~qv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
            end else begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 99) == 0));
            end
        end

        // Reset pulsed mid-frame clears outputs immediately
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h99, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_locked", 32'(locked), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'd0);
        check_all("rst_mid");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_byte(8'h12, 1'b1);
        check("rst_mid_no_output", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
